text_console: RTL
=================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows on screen.
REQ-003 SHALL have parameter BASE_ADDR, type disp_addr_t, default 0, meaning display-memory address of cell (row 0, col 0).
REQ-004 SHALL have parameter CLEAR_ATTR, 8 bits, default 8'h07, meaning the attribute written with every space during any clear.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port char_valid_i, input, 1 bit: a character is offered.
REQ-008 SHALL have port char_data_i, input, 8 bits: character code.
REQ-009 SHALL have port char_attr_i, input, 8 bits: colour attribute for a printable character.
REQ-010 SHALL have port char_ready_o, output, 1 bit: the block can accept a character.
REQ-011 SHALL have port display_wr_en_o, output, 1 bit: display-memory write strobe.
REQ-012 SHALL have port display_wr_addr_o, output, disp_addr_t: write address.
REQ-013 SHALL have port display_wr_data_o, output, disp_data_t: {attribute[15:8], char[7:0]}.
REQ-014 SHALL have ports cursor_col_o and cursor_row_o, outputs, $clog2(COLS) and $clog2(ROWS) bits: current cursor position.

Function
REQ-015 A character SHALL be accepted only on a rising clk where char_valid_i && char_ready_o; otherwise the offer is held with no side effect.
REQ-016 char_ready_o SHALL be 1 only in state IDLE; the FSM states SHALL be CLEAR, IDLE, WRITE and CLRLINE.
REQ-017 Printable (any code other than 0x08, 0x0A, 0x0C or 0x0D): in WRITE, the cycle after accept, wr_en=1, addr=BASE_ADDR+row*COLS+col, data={char_attr_i latched, code}; then col+1.
REQ-018 If col+1==COLS after a printable write, the block SHALL perform a line feed (REQ-019).
REQ-019 LF 0x0A: col=0; row+1, wrapping ROWS-1 -> 0; enter CLRLINE.
REQ-020 CLRLINE SHALL write {CLEAR_ATTR, 0x20} to the new row's COLS cells in ascending address order, one per cycle, then return to IDLE.
REQ-021 CR 0x0D: col=0; no write; return to IDLE the next cycle.
REQ-022 BS 0x08 with col>0: col-1 and write {CLEAR_ATTR, 0x20} at the new position; with col==0: no write and no cursor change.
REQ-023 FF 0x0C: cursor set to (0,0), then CLEAR.
REQ-024 CLEAR SHALL write {CLEAR_ATTR, 0x20} to all COLS*ROWS cells, addresses BASE_ADDR upward, one per cycle, then enter IDLE.
REQ-025 Row addresses SHALL be held in a running row-base register (add COLS, reset to BASE_ADDR on wrap), with no multiplier.
REQ-026 All outputs SHALL be registered; display_wr_addr_o and display_wr_data_o are don't-care when wr_en=0.
REQ-027 At most one memory write SHALL occur per cycle; a new character cannot be accepted while WRITE, CLRLINE or CLEAR is in progress.

Reset
REQ-028 While reset is high, every output SHALL be 0, the cursor SHALL be (0,0) and state SHALL be CLEAR.
REQ-029 After reset is released, the full clear (REQ-024) SHALL run before char_ready_o first rises.
REQ-030 Reset asserted mid-operation SHALL abandon that operation immediately; the full clear then restarts from BASE_ADDR.

Structure
REQ-031 The constants CHAR_BS, CHAR_LF, CHAR_FF, CHAR_CR, CHAR_SPACE and the enum console_state_t SHALL live in video_package, alongside disp_addr_t and disp_data_t.
REQ-032 The block SHALL be a single module with no sub-module; its outputs connect directly to video_main display_wr_*_i.

Verification
REQ-033 Release reset (defaults) -> 2400 writes, addr 0..2399, data 0x0720 each; char_ready_o rises the cycle after the last write.
REQ-034 At (0,0), accept 0x41 with attr 0x0F -> next cycle wr_en=1, addr 0, data 0x0F41; cursor (0,1).
REQ-035 Send 80 printables from (0,0) -> the last is written at addr 79, then 80 writes of 0x0720 to addr 80..159; cursor (1,0).
REQ-036 At row 29, send LF -> writes of 0x0720 to addr 0..79; cursor (0,0); ready asserted while valid is held low, none lost.
REQ-037 BS at col 0 -> no write; BS at col 5 -> write 0x0720 at col 4, cursor col 4; CR -> col 0, no write.
REQ-038 Assert reset midway through CLRLINE -> outputs 0 within the same cycle; after release, the full 2400-cell clear from addr 0.

Source files
------------

// File: rtl/video_package.sv
// video_package: display-memory types, control-character codes and console FSM states
// shared by the text console and the video pipeline.
package video_package;

    typedef logic [15:0] disp_addr_t;
    typedef logic [15:0] disp_data_t;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, CLRLINE} console_state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return !(c inside {CHAR_BS, CHAR_LF, CHAR_FF, CHAR_CR});
    endfunction

endpackage

// File: rtl/text_console.sv
// text_console: turns a character stream into display-memory writes, handling BS/LF/CR/FF
// and blanking the whole screen or a freshly entered line one cell per cycle.
module text_console
    import video_package::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter disp_addr_t BASE_ADDR  = '0,
    parameter logic [7:0] CLEAR_ATTR = 8'h07
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    char_valid_i,
    input  logic [7:0]              char_data_i,
    input  logic [7:0]              char_attr_i,
    output logic                    char_ready_o,
    output logic                    display_wr_en_o,
    output disp_addr_t              display_wr_addr_o,
    output disp_data_t              display_wr_data_o,
    output logic [$clog2(COLS)-1:0] cursor_col_o,
    output logic [$clog2(ROWS)-1:0] cursor_row_o
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int NW = $clog2(COLS * ROWS);
    localparam disp_data_t BLANK = {CLEAR_ATTR, CHAR_SPACE};

    console_state_t state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    disp_addr_t     row_base_q, row_base_d;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [7:0]     char_q, char_d;
    logic           ready_q, ready_d;
    logic           wr_en_q, wr_en_d;
    disp_addr_t     wr_addr_q, wr_addr_d;
    disp_data_t     wr_data_q, wr_data_d;
    logic           accept, last_col, last_row, adv;
    disp_addr_t     cur_addr;

    assign accept   = char_valid_i && ready_q;
    assign last_col = col_q == CW'(COLS - 1);
    assign last_row = row_q == RW'(ROWS - 1);
    assign cur_addr = row_base_q + disp_addr_t'(col_q);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        cnt_d      = '0;
        char_d     = char_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = cur_addr;
        wr_data_d  = BLANK;
        adv        = 1'b0;
        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = BASE_ADDR + disp_addr_t'(cnt_q);
                cnt_d     = cnt_q + 1'b1;
                state_d   = (cnt_q == NW'(COLS * ROWS - 1)) ? IDLE : CLEAR;
            end
            CLRLINE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_base_q + disp_addr_t'(cnt_q);
                cnt_d     = cnt_q + 1'b1;
                state_d   = (cnt_q == NW'(COLS - 1)) ? IDLE : CLRLINE;
            end
            // A printable that left the cursor at column 0 has wrapped onto a new line.
            WRITE: state_d = (is_printable(char_q) && col_q == '0) ? CLRLINE : IDLE;
            IDLE: begin
                if (accept) begin
                    char_d  = char_data_i;
                    state_d = WRITE;
                    if (char_data_i == CHAR_FF) begin
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = BASE_ADDR;
                        state_d    = CLEAR;
                    end else if (char_data_i == CHAR_LF) begin
                        col_d   = '0;
                        adv     = 1'b1;
                        state_d = CLRLINE;
                    end else if (char_data_i == CHAR_CR) begin
                        col_d = '0;
                    end else if (char_data_i == CHAR_BS) begin
                        wr_en_d   = col_q != '0;
                        wr_addr_d = cur_addr - 1'b1;
                        col_d     = (col_q != '0) ? col_q - 1'b1 : col_q;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {char_attr_i, char_data_i};
                        col_d     = last_col ? '0 : col_q + 1'b1;
                        adv       = last_col;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        if (adv) begin
            row_d      = last_row ? '0 : row_q + 1'b1;
            row_base_d = last_row ? BASE_ADDR : row_base_q + disp_addr_t'(COLS);
        end
        // Ready waits one cycle past the final write so a clear never overlaps new input.
        ready_d = (state_d == IDLE) && !wr_en_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= BASE_ADDR;
            cnt_q      <= '0;
            char_q     <= '0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            cnt_q      <= cnt_d;
            char_q     <= char_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign char_ready_o      = ready_q;
    assign display_wr_en_o   = wr_en_q;
    assign display_wr_addr_o = wr_addr_q;
    assign display_wr_data_o = wr_data_q;
    assign cursor_col_o      = col_q;
    assign cursor_row_o      = row_q;

endmodule
